dmem_wbuf: RTL and testbench

- Data memory for the single-cycle MIPS core: a 128 x 32 word array fronted by a posted write buffer.
- Consumes the core's memory port (CEN, WEN, OEN, A, Data2Mem) and returns ReadDataMem combinationally in the same cycle.
- Stores are absorbed into a small FIFO and drained to the array on idle cycles, so array writes leave the core's critical cycle.
- Loads forward from the buffer, so a store followed by a load is always coherent.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_wbuf_fifo.sv | 84 ++++++++
 rtl/dmem_wbuf.sv | 107 ++++++++++
 tb/tb_dmem_wbuf.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory with posted write buffer:
// default geometry, the buffer-entry record and the access decode.
package dmem_pkg;

  localparam int DMEM_AW    = 7;   // word-address width, 2**AW words
  localparam int DMEM_DW    = 32;  // data width
  localparam int DMEM_DEPTH = 4;   // write-buffer entries (power of two)

  // One posted store waiting to reach the array.
  typedef struct packed {
    logic               valid;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] data;
  } wb_entry_t;

  // What the core asks of the memory port this cycle.
  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } access_e;

  // A cycle with both WEN and OEN low counts as a write.
  function automatic access_e decode_access(input logic cen, input logic wen,
                                            input logic oen);
    if (cen)  return ACC_IDLE;
    if (!wen) return ACC_WRITE;
    if (!oen) return ACC_READ;
    return ACC_IDLE;
  endfunction

endpackage

// File: rtl/dmem_wbuf_fifo.sv
// wbuf_fifo: DEPTH-entry posted write buffer. Holds the entries, head/tail
// pointers and occupancy count, produces the address-match vector used for
// load forwarding and store coalescing, and decides drain/enqueue each cycle.
module wbuf_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,          // store accepted this cycle
  input  logic               drain_req,   // idle cycle or flush request
  input  logic [DMEM_AW-1:0] addr,
  input  logic [DMEM_DW-1:0] data,
  output logic               hit,         // a valid entry matches addr
  output logic [DMEM_DW-1:0] hit_data,
  output logic               coalesce,    // store merged into an entry
  output logic               drain,       // head entry leaves this cycle
  output logic [DMEM_AW-1:0] drain_addr,
  output logic [DMEM_DW-1:0] drain_data,
  output logic               empty,
  output logic               full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t        ent [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] match;
  logic             enq;

  // Address CAM: coalescing keeps at most one valid entry per address,
  // so OR-ing the masked data yields the single matching entry.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    match    = '0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = ent[i].valid && (ent[i].addr == addr);
      if (match[i]) hit_data = hit_data | ent[i].data;
    end
  end

  assign hit      = |match;
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign coalesce = wr && hit;
  assign enq      = wr && !hit;

  // A full buffer drains unconditionally, which frees the slot a new
  // address needs in the same cycle, so the buffer cannot overflow.
  assign drain      = !empty && (drain_req || full);
  assign drain_addr = ent[head].addr;
  // A store merging into the draining head goes straight to the array.
  assign drain_data = (coalesce && match[head]) ? data : ent[head].data;

  // Entry storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments; when full, tail equals head, and the later enqueue assignment below deliberately overrides the valid clear.
      for (int i = 0; i < DEPTH; i++) begin
        if (coalesce && match[i]) ent[i].data <= data;
      end
      if (drain) begin
        ent[head].valid <= 1'b0;
        head            <= head + PW'(1);
      end
      if (enq) begin
        ent[tail] <= '{valid: 1'b1, addr: addr, data: data};
        tail      <= tail + PW'(1);
      end
      count <= count + CW'(enq) - CW'(drain);
    end
  end

endmodule

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: data memory for the single-cycle MIPS core. A 2**AW x DW word
// array fronted by a posted write buffer (wbuf_fifo). Loads are answered
// combinationally, forwarding from the buffer when it holds the address;
// stores are posted and drained to the array on idle cycles, on flush, or
// when the buffer is full.
// Optional: define DMEM_WBUF_STATS_EN to add saturating 16-bit counters
// stat_wr, stat_coalesce and stat_fwd.
// AW and DW must match the dmem_pkg defaults, which size the buffer entry.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = DMEM_AW,
  parameter int DW    = DMEM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          OEN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] Data2Mem,
  output logic [DW-1:0] ReadDataMem,
  input  logic          flush,
  output logic          wb_empty,
  output logic          wb_full
`ifdef DMEM_WBUF_STATS_EN
  ,
  output logic [15:0]   stat_wr,
  output logic [15:0]   stat_coalesce,
  output logic [15:0]   stat_fwd
`endif
);

  access_e       acc;
  logic          wr;
  logic          idle;
  logic          out_en;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic          coalesce;
  logic          drain;
  logic [AW-1:0] drain_addr;
  logic [DW-1:0] drain_data;
  logic [DW-1:0] mem [2**AW];

  assign acc  = decode_access(CEN, WEN, OEN);
  assign wr   = (acc == ACC_WRITE);
  assign idle = (acc == ACC_IDLE);
  // Data is driven whenever OEN is qualified, so a write cycle with OEN low
  // returns the value as it stood before this store.
  assign out_en = ~CEN & ~OEN;

  wbuf_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr),
    .drain_req  (idle | flush),
    .addr       (A),
    .data       (Data2Mem),
    .hit        (hit),
    .hit_data   (hit_data),
    .coalesce   (coalesce),
    .drain      (drain),
    .drain_addr (drain_addr),
    .drain_data (drain_data),
    .empty      (wb_empty),
    .full       (wb_full)
  );

  // Backing array, written only by buffer drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the array is reset because reset must return every word to 0; this forces flops rather than a RAM macro.
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else if (drain) begin
      mem[drain_addr] <= drain_data;
    end
  end

  // Zero-latency read mux: buffer first, then the array.
  always_comb begin
    ReadDataMem = '0;
    if (out_en) ReadDataMem = hit ? hit_data : mem[A];
  end

`ifdef DMEM_WBUF_STATS_EN
  logic fwd;
  assign fwd = (acc == ACC_READ) && hit;

  // Saturating activity counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_wr       <= '0;
      stat_coalesce <= '0;
      stat_fwd      <= '0;
    end else begin
      if (wr && stat_wr != 16'hFFFF)             stat_wr       <= stat_wr + 16'd1;
      if (coalesce && stat_coalesce != 16'hFFFF) stat_coalesce <= stat_coalesce + 16'd1;
      if (fwd && stat_fwd != 16'hFFFF)           stat_fwd      <= stat_fwd + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_wbuf.sv
// Self-checking bench for dmem_wbuf. A behavioural model (word array plus a
// FIFO queue of pending stores) predicts every load result and the
// empty/full flags; directed scenarios also check fixed constants.
module tb_dmem_wbuf;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CEN = 1'b1;
  logic        WEN = 1'b1;
  logic        OEN = 1'b1;
  logic [6:0]  A = '0;
  logic [31:0] Data2Mem = '0;
  logic        flush = 1'b0;
  logic [31:0] ReadDataMem;
  logic        wb_empty;
  logic        wb_full;

  always #5 clk = ~clk;

  dmem_wbuf dut (
    .clk         (clk),
    .rst         (rst),
    .CEN         (CEN),
    .WEN         (WEN),
    .OEN         (OEN),
    .A           (A),
    .Data2Mem    (Data2Mem),
    .ReadDataMem (ReadDataMem),
    .flush       (flush),
    .wb_empty    (wb_empty),
    .wb_full     (wb_full)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: pending stores in arrival order, plus the array.
  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
  } ent_t;
  ent_t        q[$];
  logic [31:0] mdl_mem [128];

  logic [31:0] exp_rd, obs_rd;
  logic        exp_empty, obs_empty, exp_full, obs_full;

  function automatic int find(input logic [6:0] a);
    for (int i = 0; i < q.size(); i++) if (q[i].addr == a) return i;
    return -1;
  endfunction

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 128; i++) mdl_mem[i] = '0;
  endtask

  // One bus cycle: drive, sample mid-cycle, advance the model, pass the edge.
  task automatic cycle(input logic cen, input logic wen, input logic oen,
                       input logic [6:0] a, input logic [31:0] d, input logic fl);
    int idx;
    bit wr, idle, drn;
    CEN = cen; WEN = wen; OEN = oen; A = a; Data2Mem = d; flush = fl;
    #4;
    idx       = find(a);
    exp_rd    = '0;
    if (!cen && !oen) exp_rd = (idx >= 0) ? q[idx].data : mdl_mem[a];
    exp_empty = (q.size() == 0);
    exp_full  = (q.size() == DEPTH);
    obs_rd    = ReadDataMem;
    obs_empty = wb_empty;
    obs_full  = wb_full;
    wr   = !cen && !wen;
    idle = cen || (wen && oen);
    drn  = (q.size() > 0) && (idle || fl || q.size() == DEPTH);
    if (wr && idx >= 0) q[idx].data = d;
    if (drn) begin
      mdl_mem[q[0].addr] = q[0].data;
      void'(q.pop_front());
    end
    if (wr && idx < 0) q.push_back('{addr: a, data: d});
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; CEN = 1'b1; WEN = 1'b1; OEN = 1'b1; flush = 1'b0;
    model_clear();
    #2;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++; if (wb_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %b exp 1", wb_empty); end
    tests_run++; if (wb_full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %b exp 0", wb_full); end
    tests_run++; if (ReadDataMem !== 32'h0) begin tests_failed++; $display("FAIL reset_rd got %h exp 0", ReadDataMem); end
    release_reset();
    cycle(1'b0, 1'b1, 1'b0, 7'd5, 32'h0, 1'b0);
    tests_run++; if (obs_rd !== 32'h0) begin tests_failed++; $display("FAIL reset_read5 got %h exp 0", obs_rd); end
    tests_run++; if (obs_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_read5_empty got %b exp 1", obs_empty); end
  endtask

  task automatic test_forward();
    cycle(1'b0, 1'b0, 1'b1, 7'd3, 32'hDEADBEEF, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 7'd3, 32'h0, 1'b0);
    tests_run++; if (obs_rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL fwd_rd got %h exp deadbeef", obs_rd); end
    tests_run++; if (obs_empty !== 1'b0) begin tests_failed++; $display("FAIL fwd_empty got %b exp 0", obs_empty); end
    cycle(1'b1, 1'b1, 1'b1, 7'd0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 7'd3, 32'h0, 1'b0);
    tests_run++; if (obs_empty !== 1'b1) begin tests_failed++; $display("FAIL fwd_drained_empty got %b exp 1", obs_empty); end
    tests_run++; if (obs_rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL fwd_array_rd got %h exp deadbeef", obs_rd); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b0, 1'b1, 7'(i), 32'h100 + 32'(i), 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 7'd9, 32'h109, 1'b0);
    tests_run++; if (obs_full !== 1'b1) begin tests_failed++; $display("FAIL b2b_full got %b exp 1", obs_full); end
    cycle(1'b0, 1'b1, 1'b0, 7'd1, 32'h0, 1'b0);
    tests_run++; if (obs_full !== 1'b1) begin tests_failed++; $display("FAIL b2b_full_after5 got %b exp 1", obs_full); end
    tests_run++; if (obs_rd !== 32'h101) begin tests_failed++; $display("FAIL b2b_rd1 got %h exp 101", obs_rd); end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b1, 7'd0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 7'd9, 32'h0, 1'b0);
    tests_run++; if (obs_empty !== 1'b1) begin tests_failed++; $display("FAIL b2b_empty got %b exp 1", obs_empty); end
    tests_run++; if (obs_rd !== 32'h109) begin tests_failed++; $display("FAIL b2b_rd9 got %h exp 109", obs_rd); end
    cycle(1'b0, 1'b1, 1'b0, 7'd4, 32'h0, 1'b0);
    tests_run++; if (obs_rd !== 32'h104) begin tests_failed++; $display("FAIL b2b_rd4 got %h exp 104", obs_rd); end
  endtask

  task automatic test_coalesce();
    cycle(1'b0, 1'b0, 1'b1, 7'd7, 32'h11, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 7'd7, 32'h22, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 7'd7, 32'h0, 1'b0);
    tests_run++; if (obs_rd !== 32'h22) begin tests_failed++; $display("FAIL coal_rd got %h exp 22", obs_rd); end
    tests_run++; if (obs_empty !== 1'b0 || obs_full !== 1'b0) begin tests_failed++; $display("FAIL coal_flags got e=%b f=%b exp e=0 f=0", obs_empty, obs_full); end
    cycle(1'b1, 1'b1, 1'b1, 7'd0, 32'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 7'd7, 32'h0, 1'b0);
    tests_run++; if (obs_empty !== 1'b1) begin tests_failed++; $display("FAIL coal_one_entry got empty=%b exp 1", obs_empty); end
    tests_run++; if (obs_rd !== 32'h22) begin tests_failed++; $display("FAIL coal_array_rd got %h exp 22", obs_rd); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 7'(10 + i), 32'hA0 + 32'(i), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 7'd20, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 7'(10 + i), 32'h0, 1'b0);
      tests_run++; if (obs_empty !== 1'b1) begin tests_failed++; $display("FAIL flush_empty[%0d] got %b exp 1", i, obs_empty); end
      tests_run++; if (obs_rd !== 32'hA0 + 32'(i)) begin tests_failed++; $display("FAIL flush_rd[%0d] got %h exp %h", i, obs_rd, 32'hA0 + 32'(i)); end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 1'b0, 1'b1, 7'd20, 32'h55, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 7'd21, 32'h66, 1'b0);
    apply_reset();
    tests_run++; if (wb_empty !== 1'b1) begin tests_failed++; $display("FAIL midrst_empty got %b exp 1", wb_empty); end
    release_reset();
    cycle(1'b0, 1'b1, 1'b0, 7'd20, 32'h0, 1'b0);
    tests_run++; if (obs_rd !== 32'h0) begin tests_failed++; $display("FAIL midrst_rd20 got %h exp 0", obs_rd); end
    cycle(1'b0, 1'b1, 1'b0, 7'd21, 32'h0, 1'b0);
    tests_run++; if (obs_rd !== 32'h0) begin tests_failed++; $display("FAIL midrst_rd21 got %h exp 0", obs_rd); end
    cycle(1'b0, 1'b1, 1'b0, 7'd3, 32'h0, 1'b0);
    tests_run++; if (obs_rd !== 32'h0) begin tests_failed++; $display("FAIL midrst_rd3 got %h exp 0", obs_rd); end
  endtask

  // Random traffic on a narrow address window to provoke coalescing,
  // full-buffer drains and forwarding on drain cycles.
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 7'($urandom_range(0, 11)),
            32'($urandom), 1'($urandom_range(0, 9) == 0));
      tests_run++; if (obs_rd !== exp_rd) begin tests_failed++; $display("FAIL rand_rd[%0d] got %h exp %h", n, obs_rd, exp_rd); end
      tests_run++; if (obs_empty !== exp_empty) begin tests_failed++; $display("FAIL rand_empty[%0d] got %b exp %b", n, obs_empty, exp_empty); end
      tests_run++; if (obs_full !== exp_full) begin tests_failed++; $display("FAIL rand_full[%0d] got %b exp %b", n, obs_full, exp_full); end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_back_to_back();
    test_coalesce();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
